// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, loader field-format codes and loader FSM state type.
// The control decoder keys on the same opcode values.
package riscv_pkg;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_BRANCH = 7'h63;

   localparam logic [2:0] F3_WORD = 3'b010;

   localparam logic [2:0] FMT_R       = 3'd0;
   localparam logic [2:0] FMT_I_LOGIC = 3'd1;
   localparam logic [2:0] FMT_LUI     = 3'd2;
   localparam logic [2:0] FMT_SW      = 3'd3;
   localparam logic [2:0] FMT_LW      = 3'd4;
   localparam logic [2:0] FMT_JAL     = 3'd5;
   localparam logic [2:0] FMT_B       = 3'd6;
   localparam logic [2:0] FMT_ILLEGAL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FULL   = 2'd3
   } load_state_e;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: format code plus register/immediate fields -> one RV32I word.
// Immediate bits a format does not carry are dropped; no range or alignment checking.
module instr_field_packer
   import riscv_pkg::*;
(
   input  logic [2:0]  fmt_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   always_comb begin
      word_o    = 32'd0;
      illegal_o = 1'b0;
      case (fmt_i)
         FMT_R:       word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
         FMT_I_LOGIC: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
         FMT_LUI:     word_o = {imm_i[31:12], rd_i, OPC_LUI};
         FMT_SW:      word_o = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OPC_STORE};
         FMT_LW:      word_o = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OPC_LOAD};
         FMT_JAL:     word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
         FMT_B:       word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                imm_i[4:1], imm_i[11], OPC_BRANCH};
         FMT_ILLEGAL: illegal_o = 1'b1;
         default:     illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot-time program loader: accepts field bundles, encodes them and writes consecutive
// instruction-memory words over a we/ack port until memory is full.
module instr_encoder_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [2:0]            fmt_i,
   input  logic [4:0]            rd_i,
   input  logic [4:0]            rs1_i,
   input  logic [4:0]            rs2_i,
   input  logic [2:0]            funct3_i,
   input  logic [6:0]            funct7_i,
   input  logic [31:0]           imm_i,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_ack_i,
   output logic [ADDR_WIDTH:0]   word_count_o,
   output logic                  full_o,
   output logic                  err_o
);

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("instr_encoder_loader: DATA_WIDTH must be 32");
   end

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   load_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  err_q, err_d;
   logic [31:0]           wdata_q, wdata_d;

   logic [31:0] packed_word;
   logic        packed_illegal;

   instr_field_packer u_packer (
      .fmt_i     (fmt_i),
      .rd_i      (rd_i),
      .rs1_i     (rs1_i),
      .rs2_i     (rs2_i),
      .funct3_i  (funct3_i),
      .funct7_i  (funct7_i),
      .imm_i     (imm_i),
      .word_o    (packed_word),
      .illegal_o (packed_illegal)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      err_d   = err_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE, ST_FULL: begin
            if (start_i) begin
               state_d = ST_ACCEPT;
               addr_d  = '0;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_ACCEPT: begin
            // Start clears the session first; a same-cycle beat then lands at address 0.
            if (start_i) begin
               addr_d  = '0;
               count_d = '0;
               err_d   = 1'b0;
            end
            if (in_valid_i) begin
               if (packed_illegal) begin
                  err_d = 1'b1;
               end else begin
                  wdata_d = packed_word;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (mem_ack_i) begin
               count_d = count_q + COUNT_ONE;
               if (addr_q == ADDR_LAST) begin
                  state_d = ST_FULL;
               end else begin
                  addr_d  = addr_q + ADDR_ONE;
                  state_d = ST_ACCEPT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready_o   = (state_q == ST_ACCEPT);
   assign mem_we_o     = (state_q == ST_WRITE);
   assign full_o       = (state_q == ST_FULL);
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign word_count_o = count_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader with a 4-word memory; expected writes are
// queued when a beat is driven and compared as the loader issues them.
module tb_instr_encoder_loader;

   localparam int AW = 2;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] word;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset, start_i, in_valid_i, mem_ack_i;
   logic [2:0]    fmt_i, funct3_i;
   logic [4:0]    rd_i, rs1_i, rs2_i;
   logic [6:0]    funct7_i;
   logic [31:0]   imm_i;
   logic          in_ready_o, mem_we_o, full_o, err_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [AW:0]   word_count_o;

   int checks   = 0;
   int failures = 0;

   beat_t           tbl [9];
   logic [AW+31:0]  sb [$];
   logic [AW-1:0]   exp_addr;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .fmt_i        (fmt_i),
      .rd_i         (rd_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .funct3_i     (funct3_i),
      .funct7_i     (funct7_i),
      .imm_i        (imm_i),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_ack_i    (mem_ack_i),
      .word_count_o (word_count_o),
      .full_o       (full_o),
      .err_o        (err_o)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic set_fields(input beat_t b);
      fmt_i    = b.fmt;
      rd_i     = b.rd;
      rs1_i    = b.rs1;
      rs2_i    = b.rs2;
      funct3_i = b.f3;
      funct7_i = b.f7;
      imm_i    = b.imm;
   endtask

   // Drives one beat until handshake (bounded) and queues the expected write for legal formats.
   task automatic put_beat(input beat_t b);
      bit done = 1'b0;
      set_fields(b);
      in_valid_i = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready_o) begin
            tick();
            done = 1'b1;
         end
      end
      in_valid_i = 1'b0;
      if (b.fmt != 3'd7) begin
         sb.push_back({exp_addr, b.word});
         exp_addr = exp_addr + 1'b1;
      end
   endtask

   // Waits (bounded) for a write request, samples it and acknowledges it immediately.
   task automatic collect(output logic [AW-1:0] a, output logic [31:0] d, output bit got);
      got = 1'b0;
      a   = 'x;
      d   = 'x;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (mem_we_o) begin
            a   = mem_addr_o;
            d   = mem_wdata_o;
            got = 1'b1;
         end
      end
      if (got) begin
         mem_ack_i = 1'b1;
         tick();
         mem_ack_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready_o, mem_we_o, full_o, err_o} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got ready/we/full/err=%b want 0000",
                  {in_ready_o, mem_we_o, full_o, err_o});
      end
      checks++;
      if (mem_addr_o !== '0 || mem_wdata_o !== 32'd0 || word_count_o !== '0) begin
         failures++;
         $display("FAIL reset_data: got addr=%0d data=%h count=%0d want 0/0/0",
                  mem_addr_o, mem_wdata_o, word_count_o);
      end
      tick();
      checks++;
      if (in_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL idle_hold: got in_ready=%b want 0 without start", in_ready_o);
      end
   endtask

   task automatic test_addi();
      logic [AW-1:0] a; logic [31:0] d; bit got; logic [AW+31:0] e;
      do_start();
      exp_addr = '0;
      put_beat(tbl[0]);
      collect(a, d, got);
      e = sb.pop_front();
      checks++;
      if (!got || {a, d} !== e) begin
         failures++;
         $display("FAIL addi_write: got seen=%0d addr=%0d data=%h want addr=%0d data=%h",
                  got, a, d, e[AW+31:32], e[31:0]);
      end
      @(negedge clk);
      checks++;
      if (word_count_o !== 3'd1) begin
         failures++;
         $display("FAIL addi_count: got %0d want 1", word_count_o);
      end
   endtask

   task automatic run_group(input int first, input int n, input int exp_count);
      logic [AW-1:0] a; logic [31:0] d; bit got; logic [AW+31:0] e;
      do_start();
      exp_addr = '0;
      for (int i = first; i < first + n; i++) begin
         put_beat(tbl[i]);
         collect(a, d, got);
         e = sb.pop_front();
         checks++;
         if (!got || {a, d} !== e) begin
            failures++;
            $display("FAIL group_write[%0d]: got seen=%0d addr=%0d data=%h want addr=%0d data=%h",
                     i, got, a, d, e[AW+31:32], e[31:0]);
         end
      end
      @(negedge clk);
      checks++;
      if (word_count_o !== exp_count[AW:0]) begin
         failures++;
         $display("FAIL group_count[%0d]: got %0d want %0d", first, word_count_o, exp_count);
      end
   endtask

   task automatic test_mixed();
      run_group(1, 3, 3);
   endtask

   task automatic test_upper();
      run_group(4, 3, 3);
   endtask

   task automatic test_ack_stall();
      logic [AW-1:0] a; logic [31:0] d; bit got; logic [AW+31:0] e;
      do_start();
      exp_addr = '0;
      put_beat(tbl[8]);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_we_o, in_ready_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b0, 2'd0, 32'hFFF2F213}) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got we=%b ready=%b addr=%0d data=%h want 1/0/0/fff2f213",
                     i, mem_we_o, in_ready_o, mem_addr_o, mem_wdata_o);
         end
      end
      collect(a, d, got);
      e = sb.pop_front();
      checks++;
      if (!got || {a, d} !== e) begin
         failures++;
         $display("FAIL stall_write: got seen=%0d addr=%0d data=%h want addr=%0d data=%h",
                  got, a, d, e[AW+31:32], e[31:0]);
      end
      @(negedge clk);
      checks++;
      if (mem_addr_o !== 2'd1 || in_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL stall_advance: got addr=%0d ready=%b want 1/1", mem_addr_o, in_ready_o);
      end
   endtask

   task automatic test_illegal();
      beat_t bad;
      bad = tbl[0];
      bad.fmt = 3'd7;
      put_beat(bad);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_we_o, err_o, in_ready_o, mem_addr_o} !== {1'b0, 1'b1, 1'b1, 2'd1}) begin
            failures++;
            $display("FAIL illegal_beat[%0d]: got we=%b err=%b ready=%b addr=%0d want 0/1/1/1",
                     i, mem_we_o, err_o, in_ready_o, mem_addr_o);
         end
      end
      do_start();
      @(negedge clk);
      checks++;
      if (err_o !== 1'b0 || mem_addr_o !== 2'd0) begin
         failures++;
         $display("FAIL illegal_clear: got err=%b addr=%0d want 0/0", err_o, mem_addr_o);
      end
   endtask

   task automatic test_full();
      logic [AW-1:0] a; logic [31:0] d; bit got; logic [AW+31:0] e;
      int idx [4] = '{7, 0, 1, 2};
      exp_addr = '0;
      for (int i = 0; i < 4; i++) begin
         put_beat(tbl[idx[i]]);
         collect(a, d, got);
         e = sb.pop_front();
         checks++;
         if (!got || {a, d} !== e) begin
            failures++;
            $display("FAIL full_write[%0d]: got seen=%0d addr=%0d data=%h want addr=%0d data=%h",
                     i, got, a, d, e[AW+31:32], e[31:0]);
         end
      end
      @(negedge clk);
      checks++;
      if ({full_o, in_ready_o, word_count_o, mem_addr_o} !== {1'b1, 1'b0, 3'd4, 2'd3}) begin
         failures++;
         $display("FAIL full_state: got full=%b ready=%b count=%0d addr=%0d want 1/0/4/3",
                  full_o, in_ready_o, word_count_o, mem_addr_o);
      end
      set_fields(tbl[3]);
      in_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_we_o, full_o, in_ready_o} !== 3'b010) begin
            failures++;
            $display("FAIL full_ignore[%0d]: got we=%b full=%b ready=%b want 0/1/0",
                     i, mem_we_o, full_o, in_ready_o);
         end
      end
      in_valid_i = 1'b0;
      tick();
      do_start();
      @(negedge clk);
      checks++;
      if ({full_o, in_ready_o, mem_addr_o, word_count_o} !== {1'b0, 1'b1, 2'd0, 3'd0}) begin
         failures++;
         $display("FAIL full_restart: got full=%b ready=%b addr=%0d count=%0d want 0/1/0/0",
                  full_o, in_ready_o, mem_addr_o, word_count_o);
      end
   endtask

   task automatic test_start_handshake();
      logic [AW-1:0] a; logic [31:0] d; bit got; logic [AW+31:0] e;
      exp_addr = '0;
      for (int i = 0; i < 2; i++) begin
         put_beat(tbl[i]);
         collect(a, d, got);
         void'(sb.pop_front());
      end
      set_fields(tbl[5]);
      in_valid_i = 1'b1;
      start_i    = 1'b1;
      @(negedge clk);
      tick();
      in_valid_i = 1'b0;
      start_i    = 1'b0;
      sb.push_back({2'd0, tbl[5].word});
      collect(a, d, got);
      e = sb.pop_front();
      checks++;
      if (!got || {a, d} !== e) begin
         failures++;
         $display("FAIL start_beat: got seen=%0d addr=%0d data=%h want addr=%0d data=%h",
                  got, a, d, e[AW+31:32], e[31:0]);
      end
      @(negedge clk);
      checks++;
      if (word_count_o !== 3'd1) begin
         failures++;
         $display("FAIL start_count: got %0d want 1", word_count_o);
      end
   endtask

   task automatic test_reset_mid_write();
      put_beat(tbl[6]);
      sb.delete();
      @(negedge clk);
      checks++;
      if (mem_we_o !== 1'b1) begin
         failures++;
         $display("FAIL midwrite_pending: got we=%b want 1", mem_we_o);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_we_o, in_ready_o, word_count_o, mem_addr_o} !== {1'b0, 1'b0, 3'd0, 2'd0}) begin
            failures++;
            $display("FAIL midwrite_reset[%0d]: got we=%b ready=%b count=%0d addr=%0d want 0/0/0/0",
                     i, mem_we_o, in_ready_o, word_count_o, mem_addr_o);
         end
      end
   endtask

   initial begin
      //            fmt   rd     rs1    rs2    f3    f7      imm           word
      tbl[0] = '{3'd1, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'd5,        32'h00500093}; // ADDI x1,x0,5
      tbl[1] = '{3'd0, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'hFFFFFFFF, 32'h002081B3}; // ADD x3,x1,x2
      tbl[2] = '{3'd4, 5'd5,  5'd2,  5'd9,  3'd7, 7'h7F, 32'd8,        32'h00812283}; // LW x5,8(x2)
      tbl[3] = '{3'd3, 5'd17, 5'd2,  5'd5,  3'd5, 7'h7F, 32'd12,       32'h00512623}; // SW x5,12(x2)
      tbl[4] = '{3'd2, 5'd1,  5'd3,  5'd4,  3'd7, 7'h7F, 32'h12345ABC, 32'h123450B7}; // LUI x1,0x12345
      tbl[5] = '{3'd5, 5'd1,  5'd7,  5'd7,  3'd7, 7'h7F, 32'd8,        32'h008000EF}; // JAL x1,+8
      tbl[6] = '{3'd6, 5'd9,  5'd1,  5'd2,  3'd0, 7'h7F, 32'hFFFFFFFC, 32'hFE208EE3}; // BEQ x1,x2,-4
      tbl[7] = '{3'd0, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'd0,        32'h402081B3}; // SUB x3,x1,x2
      tbl[8] = '{3'd1, 5'd4,  5'd5,  5'd0,  3'd7, 7'h00, 32'hFFFFFFFF, 32'hFFF2F213}; // ANDI x4,x5,-1

      reset      = 1'b1;
      start_i    = 1'b0;
      in_valid_i = 1'b0;
      mem_ack_i  = 1'b0;
      set_fields(tbl[0]);
      exp_addr   = '0;

      test_reset();
      test_addi();
      test_mixed();
      test_upper();
      test_ack_stall();
      test_illegal();
      test_full();
      test_start_handshake();
      test_reset_mid_write();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
